// File: rtl/router_fifo.sv
// router_fifo: per-port packet FIFO of the 1x3 router, with header
// flag per entry and read-side packet length tracking.
// Ports: clock, resetn (async, active-low), soft_reset (sync flush),
//   write_enb/lfd_state/data_in (write side),
//   read_enb/data_out (read side), full, empty, ovf_err.
// Optional: define ROUTER_FIFO_OVF_ERR_EN to build the sticky ovf_err.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             ovf_err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [5:0]     pkt_cnt;
  logic [WIDTH:0] rd_word;
  logic [5:0]     hdr_len;
  logic           wr_ok;
  logic           rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);

  assign wr_ok   = write_enb && !full;
  assign rd_ok   = read_enb && !empty;
  assign rd_word = mem[rd_ptr[AW-1:0]];
  // Header byte carries the payload length in its top six bits.
  assign hdr_len = rd_word[WIDTH-1:WIDTH-6];

  // Storage is never reset; a flush only moves the pointers.
  always_ff @(posedge clock) begin
    if (wr_ok && !soft_reset) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_word[WIDTH-1:0];
        // +1 accounts for the trailing parity byte.
        if (rd_word[WIDTH]) begin
          pkt_cnt <= hdr_len + 6'd1;
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - 6'd1;
        end
      end else if (pkt_cnt == '0) begin
        data_out <= '0;
      end
    end
  end

`ifdef ROUTER_FIFO_OVF_ERR_EN
  logic ovf_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
    end else if (soft_reset) begin
      ovf_q <= 1'b0;
    end else if ((write_enb && full) || (read_enb && empty)) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: scoreboard bench for router_fifo.
// Directed vectors; read data checked by a separate monitor process.
module tb_router_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             resetn = 1'b1;
  logic             soft_reset = 1'b0;
  logic             write_enb = 1'b0;
  logic             lfd_state = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             read_enb = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             ovf_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_q [$];
  logic [7:0] sb_q [$];
  bit         ovf_exp = 1'b0;

  router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .ovf_err    (ovf_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the reference model advances at the edge.
  task automatic cyc(input bit w, input bit l, input logic [7:0] d,
                     input bit r, input bit s);
    int n;
    write_enb  = w;
    lfd_state  = l;
    data_in    = d;
    read_enb   = r;
    soft_reset = s;
    @(posedge clock);
    if (s) begin
      model_q.delete();
      ovf_exp = 1'b0;
    end else begin
      n = model_q.size();
`ifdef ROUTER_FIFO_OVF_ERR_EN
      if ((w && n == DEPTH) || (r && n == 0)) ovf_exp = 1'b1;
`endif
      if (r && n > 0) sb_q.push_back(model_q.pop_front());
      if (w && n < DEPTH) model_q.push_back(d);
    end
    @(negedge clock);
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    read_enb   = 1'b0;
    soft_reset = 1'b0;
  endtask

  // Monitor: every accepted read is compared against the scoreboard.
  initial forever begin
    logic [7:0] e;
    @(posedge clock);
    if (resetn && !soft_reset && read_enb && !empty) begin
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %0h expected none", data_out);
      end else begin
        e = sb_q.pop_front();
        chk("rd_data", {24'd0, data_out}, {24'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1 resetn = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ovf", ovf_err, 0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 1; i <= 16; i++) cyc(1, 0, 8'(i), 0, 0);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    cyc(1, 0, 8'hFF, 0, 0);
    chk("drop_full", full, 1);
    chk("drop_ovf", ovf_err, ovf_exp);
    for (int i = 0; i < 16; i++) cyc(0, 0, 8'h00, 1, 0);
    chk("drain_empty", empty, 1);
    chk("drain_full", full, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("drain_idle", data_out, 0);
    chk("drain_ovf", ovf_err, ovf_exp);

    cyc(1, 1, 8'h0C, 0, 0);
    cyc(1, 0, 8'hA1, 0, 0);
    cyc(1, 0, 8'hA2, 0, 0);
    cyc(1, 0, 8'hA3, 0, 0);
    cyc(1, 0, 8'h55, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    chk("hdr_cnt", dut.pkt_cnt, 4);
    cyc(0, 0, 8'h00, 0, 0);
    chk("hdr_hold", data_out, 8'h0C);
    chk("hdr_cnt_hold", dut.pkt_cnt, 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, 0);
    chk("par_cnt", dut.pkt_cnt, 0);
    chk("par_dout", data_out, 8'h55);
    cyc(0, 0, 8'h00, 0, 0);
    chk("pkt_idle", data_out, 0);
    chk("pkt_empty", empty, 1);

    for (int i = 0; i < 15; i++) cyc(1, 0, 8'(8'h20 + i), 0, 0);
    chk("s15_full", full, 0);
    cyc(1, 0, 8'h40, 1, 0);
    chk("sim_full", full, 0);
    chk("sim_empty", empty, 0);
    cyc(1, 0, 8'h41, 0, 0);
    chk("s16_full", full, 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 8'h00, 1, 0);
    chk("s_drain", empty, 1);
    cyc(1, 0, 8'h77, 1, 0);
    chk("emp_rw_empty", empty, 0);
    chk("emp_rw_full", full, 0);
    chk("emp_rw_dout", data_out, 0);
    chk("emp_rw_ovf", ovf_err, ovf_exp);
    cyc(0, 0, 8'h00, 1, 0);
    chk("emp_rw_drain", empty, 1);

    cyc(1, 1, 8'h08, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'(8'hB0 + i), 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("mid_hold", data_out, 8'hB0);
    chk("mid_empty", empty, 0);
    chk("mid_ovf", ovf_err, ovf_exp);
    cyc(1, 0, 8'hEE, 0, 1);
    chk("sr_empty", empty, 1);
    chk("sr_full", full, 0);
    chk("sr_dout", data_out, 0);
    chk("sr_ovf", ovf_err, 0);
    cyc(1, 0, 8'h99, 0, 0);
    chk("sr_wr_empty", empty, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("sr_rd_empty", empty, 1);

    cyc(1, 0, 8'h31, 0, 0);
    cyc(1, 0, 8'h32, 0, 0);
    cyc(1, 0, 8'h33, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    chk("pre_ar_dout", data_out, 8'h31);
    #2 resetn = 1'b0;
    #1;
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_dout", data_out, 0);
    chk("ar_ovf", ovf_err, 0);
    model_q.delete();
    ovf_exp = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    cyc(0, 0, 8'h00, 0, 0);

    chk("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination packet FIFO of the 1x3 router: one instance per output port (three total), sitting between the synchronizer and the output read interface. Stores byte-wide packet data tagged with a header flag, gives full/empty status to the synchronizer, and tracks the remaining packet length on the read side so that `data_out` returns to idle once a packet has been fully drained. Supports a synchronous soft reset so the synchronizer can flush a stalled port.

## Interface
- `DEPTH`, 16, number of entries; power of two, at least 4.
- `WIDTH`, 8, data byte width; each stored entry is WIDTH+1 bits (header flag plus byte).

- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `soft_reset` in 1: synchronous flush, active-high, from the synchronizer.
- `write_enb` in 1: write strobe, one bit of the synchronizer's `write_enb` vector.
- `lfd_state` in 1: high while `data_in` carries a packet header byte; stored as the entry's flag.
- `data_in` in WIDTH: byte to store.
- `read_enb` in 1: read strobe from the output port.
- `data_out` out WIDTH: registered read data.
- `full` out 1: no free entry.
- `empty` out 1: no stored entry; the inverse is the port's valid.
- `ovf_err` out 1: sticky error flag. Functional only with `ROUTER_FIFO_OVF_ERR_EN`; otherwise tied 0.

## Operation
- Storage: DEPTH x (WIDTH+1) array. Write and read pointers are log2(DEPTH)+1 bits wide, with the MSB used as the wrap bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - Both flags are decoded combinationally from the registered pointers.
- Write accepted when `write_enb && !full`:
  - `mem[wr_ptr] <= {lfd_state, data_in}`, then `wr_ptr` increments (modulo 2*DEPTH).
  - A write while full is dropped, and the pointer is unchanged.
  - The write is dropped while full even if a read occurs in the same cycle.
- Read accepted when `read_enb && !empty`:
  - `data_out <= mem[rd_ptr][WIDTH-1:0]`, then `rd_ptr` increments.
  - A read while empty is ignored.
- Simultaneous accepted read and write: both occur, and the occupancy is unchanged.
- Packet counter `pkt_cnt` (6 bits), updated on each accepted read:
  - Entry flag = 1 (header): `pkt_cnt <= byte[7:2] + 1`, covering payload plus parity.
  - Entry flag = 0 and `pkt_cnt != 0`: `pkt_cnt <= pkt_cnt - 1`.
- Idle output: in a cycle with no accepted read and `pkt_cnt == 0`, `data_out <= 0`. Otherwise `data_out` holds its value.
- Soft reset (`soft_reset` = 1 at a clock edge):
  - Pointers, `pkt_cnt`, `data_out` and `ovf_err` clear to 0.
  - Takes priority over a same-cycle read or write.
  - Memory contents are not cleared.
- Async reset: same state cleared immediately on `resetn` falling, independent of `clock`.
- Reset values: `data_out`=0, `full`=0, `empty`=1, `ovf_err`=0.

## Timing
- Write-to-empty-deassert: 1 cycle. A write at edge N makes `empty`=0 after edge N.
- Read latency: 1 cycle. `read_enb` sampled at edge N gives `data_out` valid after edge N.
- `full` asserts after the edge that accepts the DEPTH-th write. It deasserts after the edge that accepts a read.
- The header-length load into `pkt_cnt` is visible on the cycle after the header is read. The parity byte's read brings `pkt_cnt` to 0. `data_out` goes to 0 on the first subsequent edge without a read.
- Soft reset mid-packet: after the edge, `empty`=1, `full`=0 and `data_out`=0. A write in the next cycle is accepted normally.

## Configuration
- `ROUTER_FIFO_OVF_ERR_EN` defined:
  - `ovf_err` is set on any edge with `write_enb && full` (dropped write) or `read_enb && empty` (underflow read).
  - It stays set until `resetn` or `soft_reset`.
- Undefined: no error logic is built; `ovf_err` is a constant 0.

## Test plan
- Reset: assert `resetn`=0 mid-stream -> immediately `empty`=1, `full`=0, `data_out`=0, `ovf_err`=0.
- Fill: 16 writes of 0x01..0x10 with no reads -> `full`=1 after the 16th. A 17th write of 0xFF is dropped. 16 reads then return 0x01..0x10 in order, and `empty`=1 after the last.
- Packet length: write header 0x0C with `lfd_state`=1, then bytes 0xA1, 0xA2, 0xA3 and parity 0x55 -> after the header read `pkt_cnt`=4. After the read of 0x55 `pkt_cnt`=0, and the next idle cycle gives `data_out`=0.
- Simultaneous: with 15 entries, read and write in the same cycle -> occupancy stays 15 and `full` stays 0. With `empty`=1, read and write together -> only the write occurs.
- Soft reset: with 5 entries mid-packet, pulse `soft_reset` together with `write_enb` -> after the edge `empty`=1 and `data_out`=0, and the same-cycle write is lost.
- Macro: with `ROUTER_FIFO_OVF_ERR_EN`, write while full -> `ovf_err`=1 and held until `soft_reset`. Without the macro, the same stimulus leaves `ovf_err`=0.
